// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Core-wide definitions shared by the fetch/redirect logic:
//   XLEN        - datapath width
//   opcode_e    - RV32I major opcodes
//   pc_state_e  - PC sequencer states (BOOT, FETCH, HOLD, FLUSH)
//   redir_e     - which control-transfer source won arbitration
//   pc_plus4()  - sequential next-PC helper (wraps modulo 2^32)
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_FENCE  = 7'b0001111,
      OPC_SYSTEM = 7'b1110011
   } opcode_e;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FLUSH = 2'd3
   } pc_state_e;

   typedef enum logic [1:0] {
      REDIR_NONE   = 2'd0,
      REDIR_BRANCH = 2'd1,
      REDIR_JAL    = 2'd2,
      REDIR_JALR   = 2'd3
   } redir_e;

   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/pc_redirect_if.sv
// -----------------------------------------------------------------------------
// pc_redirect_if
// Bundles the execute-stage control-transfer inputs and the fetch-side outputs
// of the PC redirect unit.
//   master : drives br_en, br_taken, jal, jalr, ex_pc, rs1, imm, stall,
//            imem_ready; observes pc, imem_req, flush, link_addr, misalign
//   slave  : the pc_redirect block (opposite directions)
// -----------------------------------------------------------------------------
interface pc_redirect_if;
   import riscv_pkg::*;

   logic            br_en;
   logic [XLEN-1:0] br_taken;
   logic            jal;
   logic            jalr;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] imm;
   logic            stall;
   logic            imem_ready;

   logic [XLEN-1:0] pc;
   logic            imem_req;
   logic            flush;
   logic [XLEN-1:0] link_addr;
   logic            misalign;

   modport master (
      output br_en, br_taken, jal, jalr, ex_pc, rs1, imm, stall, imem_ready,
      input  pc, imem_req, flush, link_addr, misalign
   );

   modport slave (
      input  br_en, br_taken, jal, jalr, ex_pc, rs1, imm, stall, imem_ready,
      output pc, imem_req, flush, link_addr, misalign
   );

endinterface

// File: rtl/target_gen.sv
// -----------------------------------------------------------------------------
// target_gen
// Combinational redirect arbitration and target computation.
//   br_en_i, br_taken_i  - branch in execute and comparator result (bit 0)
//   jal_i, jalr_i        - jump decodes
//   ex_pc_i, rs1_i,imm_i - operands for the target adder
//   redirect_o           - a control transfer is requested this cycle
//   target_o             - resolved target (JALR has bit 0 cleared)
//   misalign_o           - target is not 4-byte aligned (bit 1 set)
// -----------------------------------------------------------------------------
module target_gen
   import riscv_pkg::*;
(
   input  logic            br_en_i,
   input  logic            br_taken_i,
   input  logic            jal_i,
   input  logic            jalr_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] imm_i,
   output logic            redirect_o,
   output logic [XLEN-1:0] target_o,
   output logic            misalign_o
);

   redir_e          kind;
   logic [XLEN-1:0] jalr_sum;

   // JALR outranks JAL (illegal double decode); either jump outranks a branch.
   always_comb begin
      kind = REDIR_NONE;
      if (jalr_i)
         kind = REDIR_JALR;
      else if (jal_i)
         kind = REDIR_JAL;
      else if (br_en_i && br_taken_i)
         kind = REDIR_BRANCH;
   end

   assign jalr_sum   = rs1_i + imm_i;
   assign redirect_o = (kind != REDIR_NONE);
   assign target_o   = (kind == REDIR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                            : (ex_pc_i + imm_i);
   // Bit 0 is always clear for JALR and IALIGN=32 makes bit 0 of branch/JAL
   // offsets irrelevant here; only bit 1 marks a misaligned word fetch.
   assign misalign_o = redirect_o && target_o[1];

endmodule

// File: rtl/pc_redirect.sv
// -----------------------------------------------------------------------------
// pc_redirect
// Fetch PC sequencer with branch/jump redirect and post-redirect bubbles.
//   clk, rst - rising-edge clock, synchronous active-high reset
//   bus      - pc_redirect_if.slave: execute-stage control transfer inputs,
//              stall and imem_ready in; pc, imem_req, flush, misalign
//              (registered) and link_addr (combinational ex_pc + 4) out
// Parameters: RESET_VECTOR, TRAP_VECTOR (misaligned target), FLUSH_CYCLES
// (bubble cycles after a redirect, 1..7).
// -----------------------------------------------------------------------------
module pc_redirect
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   pc_redirect_if.slave  bus
);

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            flush_q, flush_d;
   logic            misalign_q, misalign_d;
   logic            imem_req_q, imem_req_d;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic            tgt_misalign;
   logic            advance;

   target_gen u_target_gen (
      .br_en_i    (bus.br_en),
      .br_taken_i (bus.br_taken[0]),
      .jal_i      (bus.jal),
      .jalr_i     (bus.jalr),
      .ex_pc_i    (bus.ex_pc),
      .rs1_i      (bus.rs1),
      .imm_i      (bus.imm),
      .redirect_o (redirect),
      .target_o   (target),
      .misalign_o (tgt_misalign)
   );

   // A fetch slot is consumed only when memory accepts and the pipe is free.
   assign advance = bus.imem_ready && !bus.stall;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      misalign_d = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         default: begin
            // Redirect wins over stall/backpressure in every active state,
            // including a fresh restart of an in-progress flush.
            if (redirect) begin
               state_d    = ST_FLUSH;
               pc_d       = tgt_misalign ? TRAP_VECTOR : target;
               cnt_d      = FLUSH_INIT;
               misalign_d = tgt_misalign;
            end else if (state_q == ST_FLUSH) begin
               if (advance) begin
                  if (cnt_q <= 3'd1) begin
                     state_d = ST_FETCH;
                     pc_d    = pc_plus4(pc_q);
                     cnt_d   = 3'd0;
                  end else begin
                     cnt_d = cnt_q - 3'd1;
                  end
               end
            end else if (advance) begin
               state_d = ST_FETCH;
               pc_d    = pc_plus4(pc_q);
            end else begin
               state_d = ST_HOLD;
            end
         end
      endcase
      // Outputs are registered copies of what the next state implies.
      flush_d    = (state_d == ST_FLUSH);
      imem_req_d = (state_d != ST_BOOT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         cnt_q      <= 3'd0;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
         imem_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         flush_q    <= flush_d;
         misalign_q <= misalign_d;
         imem_req_q <= imem_req_d;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.imem_req  = imem_req_q;
   assign bus.flush     = flush_q;
   assign bus.misalign  = misalign_q;
   assign bus.link_addr = pc_plus4(bus.ex_pc);

endmodule

// File: tb/tb_pc_redirect.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect
// Directed stimulus for pc_redirect. Each stimulus cycle pushes the outputs
// expected after the following rising edge; a monitor pops one entry per edge
// and compares pc, imem_req, flush, misalign and link_addr.
// -----------------------------------------------------------------------------
module tb_pc_redirect;

   logic clk;
   logic rst;

   pc_redirect_if bus ();

   pc_redirect #(
      .RESET_VECTOR (32'h0000_0000),
      .TRAP_VECTOR  (32'h0000_0100),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       nm;
      logic [31:0] pc;
      logic        req;
      logic        fl;
      logic        mis;
      logic [31:0] link;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;

   // Drive one cycle of inputs and record the outputs required after the edge.
   task automatic cyc(input string nm, input logic r, input logic be,
                      input logic [31:0] bt, input logic j, input logic jr,
                      input logic [31:0] ep, input logic [31:0] rs,
                      input logic [31:0] im, input logic st, input logic rdy,
                      input logic [31:0] epc, input logic ereq,
                      input logic efl, input logic emis);
      exp_t x;
      @(negedge clk);
      rst            = r;
      bus.br_en      = be;
      bus.br_taken   = bt;
      bus.jal        = j;
      bus.jalr       = jr;
      bus.ex_pc      = ep;
      bus.rs1        = rs;
      bus.imm        = im;
      bus.stall      = st;
      bus.imem_ready = rdy;
      x.nm   = nm;
      x.pc   = epc;
      x.req  = ereq;
      x.fl   = efl;
      x.mis  = emis;
      x.link = ep + 32'd4;
      exp_q.push_back(x);
   endtask

   // Monitor: one comparison per rising edge that has a pending expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (bus.pc !== e.pc || bus.imem_req !== e.req || bus.flush !== e.fl ||
                bus.misalign !== e.mis || bus.link_addr !== e.link) begin
               fails++;
               $display("FAIL %s: got pc=%h req=%b flush=%b mis=%b link=%h, want pc=%h req=%b flush=%b mis=%b link=%h",
                        e.nm, bus.pc, bus.imem_req, bus.flush, bus.misalign, bus.link_addr,
                        e.pc, e.req, e.fl, e.mis, e.link);
            end else begin
               $display("[TB] %s pc=%h req=%b flush=%b mis=%b link=%h ok",
                        e.nm, bus.pc, bus.imem_req, bus.flush, bus.misalign, bus.link_addr);
            end
         end
      end
   end

   initial begin
      rst            = 1'b1;
      bus.br_en      = 1'b0;
      bus.br_taken   = 32'h0;
      bus.jal        = 1'b0;
      bus.jalr       = 1'b0;
      bus.ex_pc      = 32'h0;
      bus.rs1        = 32'h0;
      bus.imm        = 32'h0;
      bus.stall      = 1'b0;
      bus.imem_ready = 1'b1;

      //  name          rst be br_taken     jal jalr ex_pc         rs1           imm           stl rdy  exp_pc        req fl mis
      // Reset and boot
      cyc("rst_a",       1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0000_0000, 0, 0, 0);
      cyc("rst_b",       1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0000_0000, 0, 0, 0);
      cyc("boot_pc0",    0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0000_0000, 1, 0, 0);
      cyc("fetch_pc4",   0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0000_0004, 1, 0, 0);
      cyc("fetch_pc8",   0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0000_0008, 1, 0, 0);
      // Taken BEQ with two bubbles
      cyc("beq_redir",   0, 1, 32'h1,        0, 0, 32'h40,       32'h0,        32'h20,       0, 1, 32'h0000_0060, 1, 1, 0);
      cyc("beq_bub1",    0, 0, 32'h0,        0, 0, 32'h40,       32'h0,        32'h0,        0, 1, 32'h0000_0060, 1, 1, 0);
      cyc("beq_exit",    0, 0, 32'h0,        0, 0, 32'h40,       32'h0,        32'h0,        0, 1, 32'h0000_0064, 1, 0, 0);
      // Not-taken branch and br_taken masking
      cyc("bnt_mask",    0, 1, 32'hFFFF_FFFE,0, 0, 32'h40,       32'h0,        32'h20,       0, 1, 32'h0000_0068, 1, 0, 0);
      cyc("bt_no_en",    0, 0, 32'h1,        0, 0, 32'h40,       32'h0,        32'h20,       0, 1, 32'h0000_006C, 1, 0, 0);
      // JALR to a misaligned target traps
      cyc("jalr_mis",    0, 0, 32'h0,        0, 1, 32'h200,      32'h1001,     32'h1,        0, 1, 32'h0000_0100, 1, 1, 1);
      cyc("jalr_bub1",   0, 0, 32'h0,        0, 0, 32'h200,      32'h0,        32'h0,        0, 1, 32'h0000_0100, 1, 1, 0);
      cyc("jalr_exit",   0, 0, 32'h0,        0, 0, 32'h200,      32'h0,        32'h0,        0, 1, 32'h0000_0104, 1, 0, 0);
      // Arbitration: jal+jalr -> jalr; branch+jal; branch+jalr -> jalr
      cyc("jal_jalr",    0, 0, 32'h0,        1, 1, 32'h300,      32'h2001,     32'h10,       0, 1, 32'h0000_2010, 1, 1, 0);
      cyc("br_jal",      0, 1, 32'h1,        1, 0, 32'h400,      32'h0,        32'hFFFF_FFF8,0, 1, 32'h0000_03F8, 1, 1, 0);
      cyc("br_jalr",     0, 1, 32'h1,        0, 1, 32'h500,      32'h1000,     32'h4,        0, 1, 32'h0000_1004, 1, 1, 0);
      cyc("arb_bub1",    0, 0, 32'h0,        0, 0, 32'h500,      32'h0,        32'h0,        0, 1, 32'h0000_1004, 1, 1, 0);
      cyc("arb_exit",    0, 0, 32'h0,        0, 0, 32'h500,      32'h0,        32'h0,        0, 1, 32'h0000_1008, 1, 0, 0);
      // Redirect under stall, then second redirect mid-flush
      cyc("jal_stall",   0, 0, 32'h0,        1, 0, 32'h10,       32'h0,        32'h8,        1, 1, 32'h0000_0018, 1, 1, 0);
      cyc("s_bub1",      0, 0, 32'h0,        0, 0, 32'h10,       32'h0,        32'h0,        0, 1, 32'h0000_0018, 1, 1, 0);
      cyc("jal_mid",     0, 0, 32'h0,        1, 0, 32'h18,       32'h0,        32'h100,      0, 1, 32'h0000_0118, 1, 1, 0);
      cyc("m_bub1",      0, 0, 32'h0,        0, 0, 32'h18,       32'h0,        32'h0,        0, 1, 32'h0000_0118, 1, 1, 0);
      cyc("m_stall",     0, 0, 32'h0,        0, 0, 32'h18,       32'h0,        32'h0,        1, 1, 32'h0000_0118, 1, 1, 0);
      cyc("m_notready",  0, 0, 32'h0,        0, 0, 32'h18,       32'h0,        32'h0,        0, 0, 32'h0000_0118, 1, 1, 0);
      cyc("m_exit",      0, 0, 32'h0,        0, 0, 32'h18,       32'h0,        32'h0,        0, 1, 32'h0000_011C, 1, 0, 0);
      // Memory backpressure and stall in FETCH
      cyc("bp_0",        0, 0, 32'h0,        0, 0, 32'h18,       32'h0,        32'h0,        0, 0, 32'h0000_011C, 1, 0, 0);
      cyc("bp_1",        0, 0, 32'h0,        0, 0, 32'h18,       32'h0,        32'h0,        0, 0, 32'h0000_011C, 1, 0, 0);
      cyc("bp_2",        0, 0, 32'h0,        0, 0, 32'h18,       32'h0,        32'h0,        0, 0, 32'h0000_011C, 1, 0, 0);
      cyc("bp_release",  0, 0, 32'h0,        0, 0, 32'h18,       32'h0,        32'h0,        0, 1, 32'h0000_0120, 1, 0, 0);
      cyc("stall_hold",  0, 0, 32'h0,        0, 0, 32'h18,       32'h0,        32'h0,        1, 1, 32'h0000_0120, 1, 0, 0);
      cyc("stall_rel",   0, 0, 32'h0,        0, 0, 32'h18,       32'h0,        32'h0,        0, 1, 32'h0000_0124, 1, 0, 0);
      // Reset during FLUSH discards a coincident redirect
      cyc("pre_rst_jal", 0, 0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h80,       0, 1, 32'h0000_0080, 1, 1, 0);
      cyc("rst_flush",   1, 0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h80,       0, 1, 32'h0000_0000, 0, 0, 0);
      cyc("boot2",       0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0000_0000, 1, 0, 0);
      // link_addr wrap and a misaligned branch target
      cyc("link_wrap",   0, 0, 32'h0,        0, 0, 32'hFFFF_FFFC,32'h0,        32'h0,        0, 1, 32'h0000_0004, 1, 0, 0);
      cyc("br_mis",      0, 1, 32'h1,        0, 0, 32'h40,       32'h0,        32'h2,        0, 1, 32'h0000_0100, 1, 1, 1);
      cyc("bm_bub1",     0, 0, 32'h0,        0, 0, 32'h40,       32'h0,        32'h0,        0, 1, 32'h0000_0100, 1, 1, 0);
      cyc("bm_exit",     0, 0, 32'h0,        0, 0, 32'h40,       32'h0,        32'h0,        0, 1, 32'h0000_0104, 1, 0, 0);

      // Let the monitor drain the last expectation (bounded).
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, meaning the PC loaded on a misaligned control-transfer target.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of bubble cycles asserted after a redirect; the legal range is 1..7.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with these ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have the following inputs:
- br_en, 1 bit: branch instruction in execute, from the control unit.
- br_taken, 32 bits: the branch comparator result; only bit 0 is used.
- jal, 1 bit: JAL in execute.
- jalr, 1 bit: JALR in execute.
- ex_pc, 32 bits: PC of the instruction in execute.
- rs1, 32 bits: register operand for JALR.
- imm, 32 bits: sign-extended immediate.
- stall, 1 bit: pipeline hold request.
- imem_ready, 1 bit: instruction memory accepted the current request.
REQ-006 SHALL have the following outputs:
- pc, 32 bits: current fetch address.
- imem_req, 1 bit: fetch request valid.
- flush, 1 bit: squash the IF/ID stages.
- link_addr, 32 bits: ex_pc + 4, for rd writeback of JAL/JALR.
- misalign, 1 bit: one-cycle pulse on a misaligned target.

Function
REQ-007 SHALL implement states BOOT, FETCH, HOLD and FLUSH.
REQ-008 SHALL form a redirect request when any of the following is true: (br_en and br_taken[0]), jal, or jalr.
REQ-009 SHALL compute the target for branches and JAL as ex_pc + imm, modulo 2^32.
REQ-010 SHALL compute the target for JALR as (rs1 + imm) with bit 0 cleared, modulo 2^32.
REQ-011 SHALL treat a target with bit 1 set as misaligned: on the next edge it loads TRAP_VECTOR into pc instead of the target and pulses misalign high for exactly one cycle.
REQ-012 SHALL drive link_addr combinationally as ex_pc + 4 at all times, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-013 SHALL, in BOOT, hold imem_req=0 and advance to FETCH after one cycle.
REQ-014 SHALL, in FETCH, hold imem_req=1 and apply these transitions:
- imem_ready=1 and no stall: pc becomes pc+4 on the next edge.
- imem_ready=0 or stall=1: pc is held and the state moves to HOLD.
REQ-015 SHALL, in HOLD, keep imem_req=1 and pc constant, and return to FETCH (advancing pc by 4) in the first cycle where imem_ready=1 and stall=0.
REQ-016 SHALL, on a redirect in any of FETCH, HOLD or FLUSH, on the next edge:
- load pc with the target (or TRAP_VECTOR);
- enter FLUSH;
- load the bubble counter with FLUSH_CYCLES.
REQ-017 SHALL, in FLUSH, assert flush=1 and imem_req=1, and decrement the counter only on cycles with imem_ready=1 and stall=0; pc is held until the counter reaches 0.
REQ-018 SHALL, when the FLUSH counter reaches 0, deassert flush, advance pc by 4 and enter FETCH.
REQ-019 SHALL apply this priority: rst > redirect > stall > imem_ready; a redirect coincident with stall=1 is still taken.
REQ-020 SHALL, on a redirect arriving during FLUSH, reload the counter and pc with the new target with no extra gap cycle.
REQ-021 SHALL ignore br_taken when br_en=0, and ignore bits 31:1 of br_taken always.
REQ-022 SHALL resolve simultaneous jal and jalr (illegal decode) as jalr.
REQ-023 SHALL resolve simultaneous jal or jalr with a taken branch as jal/jalr.
REQ-024 SHALL have a redirect latency of exactly one clock from the request cycle to the new pc.

Reset
REQ-025 SHALL, with rst=1 at a rising edge, set pc=RESET_VECTOR, imem_req=0, flush=0, misalign=0, bubble counter=0 and state=BOOT.
REQ-026 SHALL let rst override any in-flight FLUSH or HOLD, and discard any redirect present in the same cycle.
REQ-027 SHALL register all outputs except link_addr, which is combinational.

Structure
REQ-028 SHALL place the state encoding (BOOT, FETCH, HOLD, FLUSH) and the RV32I opcode constants in a shared package, riscv_pkg, together with the other core-wide definitions.
REQ-029 SHALL instantiate one natural sub-module, target_gen, which holds the combinational target adder, the JALR bit-0 clear and the misalign detect; the state machine and counter stay in pc_redirect.

Verification
REQ-030 SHALL cover reset/boot: rst high for 2 cycles, then low with imem_ready=1 -> pc=0x0 with imem_req=0 for one cycle, then pc=0x0, 0x4, 0x8 on successive cycles.
REQ-031 SHALL cover a taken BEQ: br_en=1, br_taken=1, ex_pc=0x40, imm=0x20 -> next pc=0x60, flush=1 for exactly 2 ready cycles, then pc=0x64.
REQ-032 SHALL cover a not-taken branch and bit masking: br_en=1, br_taken=32'hFFFF_FFFE -> no redirect, pc advances by 4, flush=0.
REQ-033 SHALL cover JALR misalign: jalr=1, rs1=0x1001, imm=0x1 -> target 0x1002 (bit 1 set), pc=0x100 next cycle, misalign high exactly one cycle, link_addr=ex_pc+4.
REQ-034 SHALL cover redirect under stall, then a second redirect mid-flush: stall=1 with jal, ex_pc=0x10, imm=0x8 -> pc=0x18; a second jal at flush count 1 with ex_pc=0x18, imm=0x100 -> pc=0x118 and flush held for a full 2 further ready cycles.
REQ-035 SHALL cover memory backpressure and reset mid-flush: imem_ready=0 for 3 cycles in FETCH -> pc constant and imem_req=1 throughout; rst asserted during FLUSH -> pc=0x0, flush=0 on the next edge.
